// File: rtl/reduce_acc_i8v4_if.sv
// Handshake/data bundle between the i8v4 vector adder, the burst reducer
// and the scalar sink. The slave modport is the reducer's view. The master
// modport is the surrounding environment's view: it drives the vector
// beats and the sink-side ready.
interface reduce_acc_i8v4_if #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 5
);
    // upstream beat side
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic signed [7:0]       y_0;
    logic signed [7:0]       y_1;
    logic signed [7:0]       y_2;
    logic signed [7:0]       y_3;
    // downstream result side
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0]        out_beats;
    logic                    out_ovf;

    modport slave (
        input  in_valid, in_last, y_0, y_1, y_2, y_3, out_ready,
        output in_ready, out_valid, out_sum, out_beats, out_ovf
    );

    modport master (
        output in_valid, in_last, y_0, y_1, y_2, y_3, out_ready,
        input  in_ready, out_valid, out_sum, out_beats, out_ovf
    );
endinterface

// File: rtl/reduce_acc_i8v4.sv
// Burst reducer for i8v4 vectors: sums the four signed lanes of each beat,
// accumulates the lane sums over a burst (closed by in_last or after
// MAX_BEATS beats) and presents one signed result with its beat count and a
// sticky overflow flag.
// Optional build macro REDUCE_ACC_SATURATE_EN: on overflow, clamp the
// accumulator and the result to the ACC_W signed limits instead of wrapping.
module reduce_acc_i8v4 #(
    parameter int ACC_W     = 12,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS) + 1
) (
    input logic              clock,
    input logic              reset,
    reduce_acc_i8v4_if.slave bus
);
    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    in_rdy;
    logic                    out_vld;
    logic                    accept;
    logic                    close;

    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_q;
    logic signed [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0]        beats_q;
    logic                    ovf_out_q;

    logic signed [9:0]       ls;
    logic signed [ACC_W:0]   ls_ext;
    logic signed [ACC_W:0]   nxt;
    logic                    ovf_now;
    logic signed [ACC_W-1:0] res;

    // Beats are refused while reset is asserted and whenever a result is pending.
    assign in_rdy  = (state_q == ACC) && reset;
    assign out_vld = (state_q == DONE);
    assign accept  = bus.in_valid && in_rdy;
    assign close   = accept && (bus.in_last || (cnt_q == CNT_W'(MAX_BEATS - 1)));

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_sum   = sum_q;
    assign bus.out_beats = beats_q;
    assign bus.out_ovf   = ovf_out_q;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: close a burst into DONE, leave DONE on the output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (close) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Lane sum (exact in 10 bits) and one accumulation step at ACC_W+1 bits.
    always_comb begin
        ls      = 10'(bus.y_0) + 10'(bus.y_1) + 10'(bus.y_2) + 10'(bus.y_3);
        ls      = {{2{bus.y_0[7]}}, bus.y_0} + {{2{bus.y_1[7]}}, bus.y_1}
                + {{2{bus.y_2[7]}}, bus.y_2} + {{2{bus.y_3[7]}}, bus.y_3};
        ls_ext  = {{(ACC_W - 9){ls[9]}}, ls};
        nxt     = {acc_q[ACC_W-1], acc_q} + ls_ext;
        ovf_now = (nxt[ACC_W] != nxt[ACC_W-1]);
`ifdef REDUCE_ACC_SATURATE_EN
        if (ovf_now) begin
            res = nxt[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                             : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            res = nxt[ACC_W-1:0];
        end
`else
        res = nxt[ACC_W-1:0];
`endif
    end

    // Accumulator, beat counter and result registers; the result is only
    // written on close, and the burst state is cleared on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            beats_q   <= '0;
            ovf_out_q <= 1'b0;
        end else if (accept) begin
            if (close) begin
                acc_q     <= '0;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
                sum_q     <= res;
                beats_q   <= cnt_q + CNT_W'(1);
                ovf_out_q <= ovf_q | ovf_now;
            end else begin
                acc_q <= res;
                cnt_q <= cnt_q + CNT_W'(1);
                ovf_q <= ovf_q | ovf_now;
            end
        end
    end
endmodule

// File: tb/tb_reduce_acc_i8v4.sv
// Directed bench for reduce_acc_i8v4 (ACC_W=12, MAX_BEATS=16).
module tb_reduce_acc_i8v4;
    localparam int ACC_W     = 12;
    localparam int MAX_BEATS = 16;
    localparam int CNT_W     = 5;

`ifdef REDUCE_ACC_SATURATE_EN
    localparam int POS_OVF_SUM = 2047;
    localparam int NEG_OVF_SUM = -2048;
`else
    localparam int POS_OVF_SUM = -1556;
    localparam int NEG_OVF_SUM = 1536;
`endif

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;

    reduce_acc_i8v4_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    reduce_acc_i8v4 #(.ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic signed [7:0] y0, y1, y2, y3;
        bit                last;
        int                idle;
        bit                chk;
        int                e_sum;
        int                e_beats;
        int                e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic signed [7:0] a, b, c, d, input bit last);
        int n;
        n = 0;
        bus.y_0 = a; bus.y_1 = b; bus.y_2 = c; bus.y_3 = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) check("beat_accept_timeout", 0, 1);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic take_result(input string name, input int s, input int bts, input int ov);
        check({name, "_valid"}, int'(bus.out_valid), 1);
        check({name, "_sum"},   int'($signed(bus.out_sum)), s);
        check({name, "_beats"}, int'(bus.out_beats), bts);
        check({name, "_ovf"},   int'(bus.out_ovf), ov);
        bus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.out_ready = 1'b0;
        check({name, "_valid_drop"}, int'(bus.out_valid), 0);
        check({name, "_ready_back"}, int'(bus.in_ready), 1);
    endtask

    task automatic push(input int a, b, c, d, input bit last, input int idle,
                        input bit chk, input int s, input int bts, input int ov);
        vec_t v;
        v.y0 = 8'(a); v.y1 = 8'(b); v.y2 = 8'(c); v.y3 = 8'(d);
        v.last = last; v.idle = idle; v.chk = chk;
        v.e_sum = s; v.e_beats = bts; v.e_ovf = ov;
        vecs.push_back(v);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        bus.y_0 = '0; bus.y_1 = '0; bus.y_2 = '0; bus.y_3 = '0;

        // single beat, multi-beat with idle gap, positive/negative overflow,
        // and clean bursts after each overflow
        push(-3, 5, 2, 2, 1, 0, 1, 6, 1, 0);
        push(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        push(-4, 2, 2, 1, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, -10, 1, 0, 1, -5, 3, 0);
        for (int i = 0; i < 4; i++) push(127, 127, 127, 127, 0, 0, 0, 0, 0, 0);
        push(127, 127, 127, 127, 1, 0, 1, POS_OVF_SUM, 5, 1);
        push(1, 0, 0, 0, 1, 0, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) push(-128, -128, -128, -128, 0, 0, 0, 0, 0, 0);
        push(-128, -128, -128, -128, 1, 0, 1, NEG_OVF_SUM, 5, 1);
        push(-1, -1, 0, 0, 1, 0, 1, -2, 1, 0);

        // reset state
        repeat (16) @(negedge clock);
        check("rst_in_ready",  int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_sum",   int'($signed(bus.out_sum)), 0);
        check("rst_out_beats", int'(bus.out_beats), 0);
        check("rst_out_ovf",   int'(bus.out_ovf), 0);
        reset = 1'b1;
        @(negedge clock);

        // table-driven bursts
        foreach (vecs[i]) begin
            repeat (vecs[i].idle) @(negedge clock);
            send_beat(vecs[i].y0, vecs[i].y1, vecs[i].y2, vecs[i].y3, vecs[i].last);
            if (vecs[i].chk) take_result($sformatf("vec%0d", i), vecs[i].e_sum,
                                         vecs[i].e_beats, vecs[i].e_ovf);
            else check($sformatf("vec%0d_no_valid", i), int'(bus.out_valid), 0);
        end

        // auto-close after MAX_BEATS, then a beat held off while DONE
        for (int i = 0; i < MAX_BEATS; i++) send_beat(0, 0, 0, 1, 0);
        check("auto_valid", int'(bus.out_valid), 1);
        check("auto_sum",   int'($signed(bus.out_sum)), 16);
        check("auto_beats", int'(bus.out_beats), 16);
        check("auto_ovf",   int'(bus.out_ovf), 0);
        bus.y_0 = 8'sd0; bus.y_1 = 8'sd0; bus.y_2 = 8'sd0; bus.y_3 = 8'sd3;
        bus.in_last = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold%0d_in_ready", i), int'(bus.in_ready), 0);
            check($sformatf("hold%0d_sum", i), int'($signed(bus.out_sum)), 16);
            check($sformatf("hold%0d_valid", i), int'(bus.out_valid), 1);
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.out_ready = 1'b0;
        check("held_beat_ready", int'(bus.in_ready), 1);
        check("held_beat_no_valid", int'(bus.out_valid), 0);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        take_result("held_beat", 3, 1, 0);

        // asynchronous reset mid-burst
        send_beat(50, 0, 0, 0, 0);
        send_beat(60, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("midrst_in_ready", int'(bus.in_ready), 0);
        check("midrst_valid",    int'(bus.out_valid), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send_beat(2, 0, 0, 0, 1);
        take_result("after_midrst", 2, 1, 0);

        // asynchronous reset while a result is pending
        send_beat(7, 0, 0, 0, 1);
        check("pre_donerst_valid", int'(bus.out_valid), 1);
        #2 reset = 1'b0;
        #1;
        check("donerst_valid", int'(bus.out_valid), 0);
        check("donerst_sum",   int'($signed(bus.out_sum)), 0);
        check("donerst_beats", int'(bus.out_beats), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send_beat(2, 0, 0, 0, 1);
        take_result("after_donerst", 2, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/reduce_acc_i8v4.md
Name: reduce_acc_i8v4

Overview:
- Downstream consumer of the 4-lane int8 vector adder.
- Takes one i8v4 result vector (y_0..y_3) per beat and sums its four signed lanes.
- Accumulates these lane sums over a burst of beats, then presents one signed result with beat count and overflow flag.
- Valid/ready handshake on both sides so it can sit between the vector adder and a scalar sink.

Parameters:
- ACC_W, 12, accumulator/result width in bits (signed two's complement, ≥10).
- MAX_BEATS, 16, maximum beats per burst; burst is force-closed at this count.
- CNT_W, $clog2(MAX_BEATS)+1, width of the beat counter and out_beats.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  vector beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_last  in  1  beat closes the burst; qualified by in_valid&in_ready.
- y_0..y_3  in  8 each  signed int8 lanes from the vector adder.
- out_valid  out  1  result available.
- out_ready  in  1  sink takes the result.
- out_sum  out  ACC_W  signed accumulated burst sum.
- out_beats  out  CNT_W  number of beats in the burst (1..MAX_BEATS).
- out_ovf  out  1  sticky: accumulation left the ACC_W signed range during this burst.

Behaviour:
- Reset (reset==0, asynchronous): state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_beats=0, out_ovf=0. in_ready is 0 while reset is asserted.
- Lane sum is combinational: ls = sext10(y_0)+sext10(y_1)+sext10(y_2)+sext10(y_3). Range is −512..508, so it is exact. It is sign-extended to ACC_W+1 for the add.
- FSM has two states:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready.
- On accept in ACC:
  - nxt = acc + ls, computed at ACC_W+1 bits.
  - ovf_now = nxt does not fit in ACC_W signed.
  - acc <= nxt[ACC_W-1:0] (wrap), cnt <= cnt+1, ovf <= ovf | ovf_now.
- Closing: if accept & (in_last | cnt==MAX_BEATS-1):
  - register out_sum <= wrapped nxt, out_beats <= cnt+1, out_ovf <= ovf|ovf_now.
  - go to DONE.
  - Clear acc, cnt and ovf to 0 in the same edge.
- Latency: out_valid rises on the clock edge that accepts the closing beat. The result is visible the cycle after the last beat is presented.
- DONE: out_sum, out_beats and out_ovf are held stable while out_valid=1 & out_ready=0.
- out_valid & out_ready → ACC on the next edge. in_ready=1 from that next cycle; there is no same-cycle pass-through (one bubble per burst).
- in_valid while in DONE: the beat is not accepted and must be held by the upstream.
- No accept cycles: acc and cnt are unchanged, so idle gaps inside a burst are legal.
- Single-beat burst (in_last on the first beat): out_beats=1, out_sum=ls.
- in_last together with cnt==MAX_BEATS-1 closes once (no double close).
- Reset asserted mid-burst or in DONE: the partial burst and pending result are discarded and all state returns to reset values immediately.
- out_* registers are updated only on close, so outputs are glitch-free.

Optional Feature:
- Macro: REDUCE_ACC_SATURATE_EN.
- Defined: on ovf_now, acc and the closing out_sum clamp to +2^(ACC_W-1)−1 or −2^(ACC_W-1) (sign of nxt) instead of wrapping. Further beats keep accumulating from the clamped value. out_ovf is still set.
- Undefined: two's-complement wrap as above.

Test Plan:
1. Reset held 16 cycles, then one beat y=(−3,5,2,2) with in_last, out_ready=1 → next cycle out_valid=1, out_sum=6, out_beats=1, out_ovf=0; in_ready=1 again the following cycle.
2. Three beats (1,1,1,1),(−4,2,2,1),(0,0,0,−10), in_last on the third, with one idle cycle between beats 1 and 2 → out_sum=−5, out_beats=3.
3. 16 beats of (0,0,0,1) with no in_last → auto-close: out_sum=16, out_beats=16. A 17th beat offered in DONE with out_ready=0 for 4 cycles → in_ready=0, outputs stable; accepted only after the handshake.
4. ACC_W=12, five beats (127,127,127,127) with last → without macro out_sum=−1556, out_ovf=1. With REDUCE_ACC_SATURATE_EN, out_sum=2047, out_ovf=1. The following burst (1,0,0,0) → out_ovf=0, out_sum=1.
5. reset pulsed low asynchronously mid-burst after two beats, and again while in DONE → out_valid falls immediately. The next single-beat burst (2,0,0,0) yields out_sum=2, out_beats=1.
